// File: rtl/spi_seq_pkg.sv
// spi_seq_pkg: state encoding and default word width shared by spi_byte_sequencer
package spi_seq_pkg;
  localparam int DEF_DATA_BITS = 8;
  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_EN_REQ   = 3'd1;
  localparam logic [2:0] S_EN_WAIT  = 3'd2;
  localparam logic [2:0] S_BIT_REQ  = 3'd3;
  localparam logic [2:0] S_BIT_WAIT = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;
  localparam logic [2:0] S_DIS_REQ  = 3'd6;
  localparam logic [2:0] S_DIS_WAIT = 3'd7;
endpackage

// File: rtl/spi_byte_sequencer.sv
// spi_byte_sequencer: byte stream to bit-level SPI driver commands; SPI_BYTE_SEQUENCER_ABORT_EN adds an abort input
module spi_byte_sequencer
  import spi_seq_pkg::*;
#(
  parameter int DATA_BITS = DEF_DATA_BITS,
  parameter int CNT_BITS  = 4
) (
  input  logic                 clock,
  input  logic                 reset_n,
`ifdef SPI_BYTE_SEQUENCER_ABORT_EN
  input  logic                 abort,
`endif
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [DATA_BITS-1:0] cmd_data,
  input  logic                 cmd_last,
  output logic                 rsp_valid,
  output logic [DATA_BITS-1:0] rsp_data,
  output logic                 frame_active,
  input  logic                 drv_idle,
  output logic                 drv_do_enable,
  output logic                 drv_do_disable,
  output logic                 drv_do_transfer,
  output logic                 drv_wdata,
  input  logic                 drv_ack,
  input  logic                 drv_rdata
);
  logic [2:0]           state_q, state_d;
  logic [DATA_BITS-1:0] tx_sr_q, tx_sr_d;
  logic [DATA_BITS-1:0] rx_sr_q, rx_sr_d;
  logic [DATA_BITS-1:0] rsp_data_q, rsp_data_d;
  logic [CNT_BITS-1:0]  bit_cnt_q, bit_cnt_d;
  logic                 last_q, last_d;
  logic                 frame_q, frame_d;
  logic                 abort_q, abort_d;
  logic                 ab;
  logic                 ab_any;
  logic [DATA_BITS-1:0] rx_next;
`ifdef SPI_BYTE_SEQUENCER_ABORT_EN
  assign ab = abort;
`else
  assign ab = 1'b0;
`endif
  assign ab_any  = abort_q | ab;
  assign rx_next = {rx_sr_q[DATA_BITS-2:0], drv_rdata};
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      rsp_data_q <= '0;
      bit_cnt_q  <= '0;
      last_q     <= 1'b0;
      frame_q    <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      rsp_data_q <= rsp_data_d;
      bit_cnt_q  <= bit_cnt_d;
      last_q     <= last_d;
      frame_q    <= frame_d;
      abort_q    <= abort_d;
    end
  end
  // An abort seen during a WAIT is remembered until the outstanding ack arrives
  always_comb begin
    state_d    = state_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    rsp_data_d = rsp_data_q;
    bit_cnt_d  = bit_cnt_q;
    last_d     = last_q;
    frame_d    = frame_q;
    abort_d    = abort_q;
    case (state_q)
      S_IDLE: begin
        if (ab) state_d = frame_q ? S_DIS_REQ : S_IDLE;
        else if (cmd_valid) begin
          tx_sr_d   = cmd_data;
          last_d    = cmd_last;
          bit_cnt_d = '0;
          state_d   = frame_q ? S_BIT_REQ : S_EN_REQ;
        end
      end
      S_EN_REQ:  state_d = ab ? S_IDLE : drv_idle ? S_EN_WAIT : S_EN_REQ;
      S_EN_WAIT: begin
        abort_d = ab_any;
        if (drv_ack) begin
          frame_d   = 1'b1;
          bit_cnt_d = '0;
          abort_d   = 1'b0;
          state_d   = ab_any ? S_DIS_REQ : S_BIT_REQ;
        end
      end
      S_BIT_REQ: state_d = ab ? S_DIS_REQ : drv_idle ? S_BIT_WAIT : S_BIT_REQ;
      S_BIT_WAIT: begin
        abort_d = ab_any;
        if (drv_ack) begin
          rx_sr_d   = rx_next;
          tx_sr_d   = tx_sr_q << 1;
          bit_cnt_d = bit_cnt_q + 1'b1;
          abort_d   = 1'b0;
          if (ab_any) state_d = S_DIS_REQ;
          else if (bit_cnt_q == CNT_BITS'(DATA_BITS-1)) begin
            rsp_data_d = rx_next;
            state_d    = S_DONE;
          end else state_d = S_BIT_REQ;
        end
      end
      S_DONE:     state_d = last_q ? S_DIS_REQ : S_IDLE;
      S_DIS_REQ:  state_d = drv_idle ? S_DIS_WAIT : S_DIS_REQ;
      S_DIS_WAIT: begin
        if (drv_ack) begin
          frame_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_comb begin
    cmd_ready       = reset_n && state_q == S_IDLE && !ab;
    drv_do_enable   = state_q == S_EN_REQ && drv_idle && !ab;
    drv_do_transfer = state_q == S_BIT_REQ && drv_idle && !ab;
    drv_do_disable  = state_q == S_DIS_REQ && drv_idle;
    drv_wdata       = state_q == S_BIT_REQ ? tx_sr_q[DATA_BITS-1] : 1'b0;
    rsp_valid       = state_q == S_DONE;
    rsp_data        = rsp_data_q;
    frame_active    = frame_q;
  end
endmodule

// File: tb/tb_spi_byte_sequencer.sv
// tb_spi_byte_sequencer: sequencer against a random-latency loopback driver model and a word-level reference
module tb_spi_byte_sequencer;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic cmd_valid = 1'b0;
  logic cmd_last = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic cmd_ready, rsp_valid, frame_active;
  logic [7:0] rsp_data;
  logic drv_idle = 1'b1;
  logic drv_ack = 1'b0;
  logic drv_rdata = 1'b0;
  logic drv_do_enable, drv_do_disable, drv_do_transfer, drv_wdata;
`ifdef SPI_BYTE_SEQUENCER_ABORT_EN
  logic abort = 1'b0;
`endif
  spi_byte_sequencer dut (
    .clock(clock), .reset_n(reset_n),
`ifdef SPI_BYTE_SEQUENCER_ABORT_EN
    .abort(abort),
`endif
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data), .cmd_last(cmd_last),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .frame_active(frame_active),
    .drv_idle(drv_idle), .drv_do_enable(drv_do_enable), .drv_do_disable(drv_do_disable),
    .drv_do_transfer(drv_do_transfer), .drv_wdata(drv_wdata), .drv_ack(drv_ack), .drv_rdata(drv_rdata)
  );
  always #5 clock = ~clock;
  int total = 0;
  int bad = 0;
  int proto_err = 0;
  int n_fall = 0;
  int busy = 0;
  int cnt = 0;
  bit block = 1'b0;
  bit miso_zero = 1'b0;
  bit open_frame = 1'b0;
  logic pend = 1'b0;
  logic prev_fa = 1'b0;
  logic s_en, s_dis, s_xf, s_wd, s_rv, s_fa, s_rst, s_idle;
  logic [7:0] s_rd;
  int log_q[$];
  int exp_log[$];
  bit wb_q[$];
  bit exp_wb[$];
  logic [7:0] rsp_q[$];
  logic [7:0] exp_rsp[$];
  // Driver model: samples commands at negedge (pre-edge values), reacts 1ns after the edge
  always begin
    @(negedge clock);
    s_en = drv_do_enable; s_dis = drv_do_disable; s_xf = drv_do_transfer; s_wd = drv_wdata;
    s_rv = rsp_valid; s_rd = rsp_data; s_fa = frame_active; s_rst = !reset_n; s_idle = drv_idle;
    @(posedge clock);
    #1;
    drv_ack = 1'b0;
    if (s_rst) begin
      busy = 0;
    end else begin
      if (s_rv) rsp_q.push_back(s_rd);
      if (prev_fa && !s_fa) n_fall++;
      if (int'(s_en) + int'(s_dis) + int'(s_xf) > 1 || ((s_en || s_dis || s_xf) && (busy != 0 || !s_idle))) proto_err++;
      if (s_en || s_dis || s_xf) begin
        log_q.push_back(s_en ? 1 : s_xf ? 2 : 3);
        if (s_xf) begin wb_q.push_back(s_wd); pend = s_wd; end
        busy = 1;
        cnt = $urandom_range(1, 6);
      end else if (busy != 0) begin
        cnt--;
        if (cnt == 0) begin
          busy = 0;
          drv_ack = 1'b1;
          drv_rdata = miso_zero ? 1'b0 : pend;
        end
      end
    end
    prev_fa = s_fa;
    drv_idle = busy == 0 && !block;
  end
  task automatic tick();
    @(posedge clock);
    #2;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // Reference: a word opens a frame if none is open, sends its bits MSB first, closes on last
  function automatic void model_word(input logic [7:0] d, input bit l);
    if (!open_frame) exp_log.push_back(1);
    for (int i = 7; i >= 0; i--) begin
      exp_log.push_back(2);
      exp_wb.push_back(d[i]);
    end
    if (l) exp_log.push_back(3);
    open_frame = !l;
    exp_rsp.push_back(miso_zero ? 8'h00 : d);
  endfunction
  function automatic int nx();
    int c = 0;
    foreach (log_q[i]) if (log_q[i] == 2) c++;
    return c;
  endfunction
  task automatic clear_all();
    log_q.delete(); exp_log.delete(); wb_q.delete(); exp_wb.delete(); rsp_q.delete(); exp_rsp.delete();
  endtask
  task automatic compare(input string tag);
    int dl = -1;
    int dw = -1;
    int dr = -1;
    check({tag, "_log_len"}, 32'(log_q.size()), 32'(exp_log.size()));
    for (int i = 0; i < log_q.size() && i < exp_log.size(); i++) if (dl < 0 && log_q[i] != exp_log[i]) dl = i;
    check({tag, "_log_first_diff"}, 32'(dl), 32'(-1));
    check({tag, "_bits_len"}, 32'(wb_q.size()), 32'(exp_wb.size()));
    for (int i = 0; i < wb_q.size() && i < exp_wb.size(); i++) if (dw < 0 && wb_q[i] != exp_wb[i]) dw = i;
    check({tag, "_bits_first_diff"}, 32'(dw), 32'(-1));
    check({tag, "_rsp_count"}, 32'(rsp_q.size()), 32'(exp_rsp.size()));
    for (int i = 0; i < rsp_q.size() && i < exp_rsp.size(); i++) if (dr < 0 && rsp_q[i] !== exp_rsp[i]) dr = i;
    check({tag, "_rsp_first_diff"}, 32'(dr), 32'(-1));
    clear_all();
  endtask
  task automatic offer(input logic [7:0] d, input bit l);
    int k = 0;
    cmd_data = d; cmd_last = l; cmd_valid = 1'b1;
    while (!cmd_ready && k < 300) begin tick(); k++; end
    if (k >= 300) check("accept_timeout", 32'(k), 32'(0));
    tick();
    cmd_valid = 1'b0;
  endtask
  task automatic wait_rsp(input int n);
    int k = 0;
    while (rsp_q.size() < n && k < 500) begin tick(); k++; end
    if (k >= 500) check("rsp_timeout", 32'(rsp_q.size()), 32'(n));
  endtask
  task automatic wait_closed();
    int k = 0;
    while (frame_active && k < 100) begin tick(); k++; end
    if (k >= 100) check("close_timeout", 32'(frame_active), 32'(0));
  endtask
  task automatic wait_xfers(input int n);
    int k = 0;
    while (nx() < n && k < 300) begin tick(); k++; end
    if (k >= 300) check("xfer_timeout", 32'(nx()), 32'(n));
  endtask
  task automatic send(input logic [7:0] d, input bit l);
    int t = rsp_q.size() + 1;
    offer(d, l);
    wait_rsp(t);
    if (l) wait_closed();
  endtask
  initial begin
    int hi;
    int k;
    int x0;
    logic [7:0] d;
    bit l;
    repeat (3) tick();
    check("rst_ctrl", 32'({cmd_ready, rsp_valid, frame_active, drv_do_enable, drv_do_disable, drv_do_transfer, drv_wdata}), 32'(0));
    check("rst_rsp_data", 32'(rsp_data), 32'(0));
    reset_n = 1'b1;
    tick();
    check("idle_ready", 32'(cmd_ready), 32'(1));
    clear_all();
    model_word(8'hA5, 1'b1);
    n_fall = 0;
    send(8'hA5, 1'b1);
    compare("a5");
    check("a5_frame_off", 32'(frame_active), 32'(0));
    check("a5_rsp_hold", 32'(rsp_data), 32'(8'hA5));
    n_fall = 0;
    model_word(8'h3C, 1'b0);
    model_word(8'hFF, 1'b1);
    send(8'h3C, 1'b0);
    check("b2b_frame_between", 32'(frame_active), 32'(1));
    send(8'hFF, 1'b1);
    compare("b2b");
    check("b2b_frame_falls", 32'(n_fall), 32'(1));
    miso_zero = 1'b1;
    model_word(8'hFF, 1'b1);
    offer(8'hFF, 1'b1);
    hi = 0;
    k = 0;
    while ((rsp_q.size() < 1 || frame_active) && k < 500) begin
      if (cmd_ready) hi++;
      tick();
      k++;
    end
    check("miso0_ready_low", 32'(hi), 32'(0));
    check("miso0_back_idle", 32'(cmd_ready), 32'(1));
    compare("miso0");
    miso_zero = 1'b0;
    model_word(8'h5A, 1'b1);
    offer(8'h5A, 1'b1);
    wait_xfers(3);
    block = 1'b1;
    repeat (12) tick();
    x0 = nx();
    repeat (10) tick();
    check("blk_no_pulse", 32'(nx()), 32'(3));
    check("blk_stable", 32'(nx()), 32'(x0));
    block = 1'b0;
    repeat (3) tick();
    check("blk_one_pulse", 32'(nx()), 32'(4));
    wait_rsp(1);
    wait_closed();
    compare("blk");
    offer(8'hC3, 1'b1);
    wait_xfers(4);
    reset_n = 1'b0;
    tick();
    check("mid_rst_ctrl", 32'({cmd_ready, rsp_valid, frame_active, drv_do_enable, drv_do_disable, drv_do_transfer, drv_wdata}), 32'(0));
    check("mid_rst_rsp_data", 32'(rsp_data), 32'(0));
    tick();
    reset_n = 1'b1;
    clear_all();
    open_frame = 1'b0;
    tick();
    model_word(8'h81, 1'b1);
    send(8'h81, 1'b1);
    compare("post_rst");
    check("post_rst_rsp", 32'(rsp_data), 32'(8'h81));
    for (int i = 0; i < 20; i++) begin
      d = 8'($urandom);
      l = (i == 19) || ($urandom_range(0, 3) == 0);
      model_word(d, l);
      send(d, l);
    end
    compare("rand");
`ifdef SPI_BYTE_SEQUENCER_ABORT_EN
    exp_log.push_back(1);
    for (int i = 0; i < 3; i++) exp_log.push_back(2);
    exp_log.push_back(3);
    exp_wb.push_back(1'b1); exp_wb.push_back(1'b0); exp_wb.push_back(1'b0);
    offer(8'h96, 1'b1);
    wait_xfers(3);
    abort = 1'b1;
    repeat (2) tick();
    wait_closed();
    tick();
    abort = 1'b0;
    compare("abort");
    check("abort_frame_off", 32'(frame_active), 32'(0));
    check("abort_idle", 32'(cmd_ready), 32'(1));
`endif
    check("protocol_errors", 32'(proto_err), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/spi_byte_sequencer.md
Name: spi_byte_sequencer

Overview:
- Byte-level front end that sits directly upstream of the bit-level SPI master driver.
- Accepts bytes with optional end-of-frame marks and issues the driver's enable/transfer/disable commands, one bit per transfer, MSB first.
- Assembles the bits read back from the slave into a response byte.
- Owns the frame (SCS) lifecycle so that clients see a simple byte stream.

Parameters:
- DATA_BITS, 8: bits per word; also the number of transfer commands issued per accepted word.
- CNT_BITS, 4: width of the bit counter; must satisfy 2^CNT_BITS > DATA_BITS.

Ports:
- clock  in  1  system clock, shared with the driver.
- reset_n  in  1  synchronous active-low reset.
- cmd_valid  in  1  client offers a word.
- cmd_ready  out  1  sequencer accepts the word this cycle.
- cmd_data  in  DATA_BITS  word to send, MSB sent first.
- cmd_last  in  1  deassert SCS after this word.
- rsp_valid  out  1  one-cycle pulse: rsp_data is valid.
- rsp_data  out  DATA_BITS  word received from the slave, MSB first.
- frame_active  out  1  high while SCS is held low by this block.
- drv_idle  in  1  driver ready for a command.
- drv_do_enable  out  1  driver enable command pulse.
- drv_do_disable  out  1  driver disable command pulse.
- drv_do_transfer  out  1  driver transfer command pulse.
- drv_wdata  out  1  bit to send; valid during the drv_do_transfer cycle.
- drv_ack  in  1  driver command complete.
- drv_rdata  in  1  received bit; valid in the drv_ack cycle.

Behaviour:
- Reset (reset_n low at a clock edge):
  - State = S_IDLE; all drv_do_* = 0, drv_wdata = 0.
  - cmd_ready = 0, rsp_valid = 0, rsp_data = 0, frame_active = 0.
  - Internal shift registers and bit counter cleared.
  - Reset mid-operation abandons the frame silently; the driver is reset by the same reset_n.
- Handshake:
  - cmd_ready = 1 only in S_IDLE. A word is accepted on a cycle with cmd_valid & cmd_ready.
  - On acceptance, latch cmd_data into tx_sr and cmd_last into last_q.
  - Next state: S_EN_REQ if frame_active = 0, else S_BIT_REQ.
- Driver protocol:
  - Every command uses a REQ/WAIT pair.
  - In REQ: when drv_idle = 1, pulse the matching drv_do_* for exactly one cycle and go to WAIT. Otherwise hold in REQ with all drv_do_* low.
  - In WAIT: hold until drv_ack = 1, with all drv_do_* low. drv_ack is never expected in the same cycle as the pulse.
  - Only one drv_do_* is ever high at a time.
- States:
  - S_IDLE.
  - S_EN_REQ -> S_EN_WAIT. On ack: frame_active <= 1, bit_cnt <= 0, go to S_BIT_REQ.
  - S_BIT_REQ: drv_wdata = tx_sr[DATA_BITS-1]; go to S_BIT_WAIT.
  - S_BIT_WAIT, on ack:
    - rx_sr <= {rx_sr[DATA_BITS-2:0], drv_rdata}; tx_sr shifts left by 1; bit_cnt++.
    - If bit_cnt == DATA_BITS-1: go to S_DONE. Otherwise go to S_BIT_REQ.
  - S_DONE (one cycle): rsp_valid = 1, rsp_data = rx_sr. Go to S_DIS_REQ if last_q, else S_IDLE.
  - S_DIS_REQ -> S_DIS_WAIT. On ack: frame_active <= 0, go to S_IDLE.
- rsp_data holds its value until the next S_DONE.
- rsp has no backpressure; the client must sample the rsp_valid pulse.
- Latency, with a driver that acks in A cycles:
  - Non-first word: about DATA_BITS*(A+1) + 2 cycles from accept to rsp_valid.
  - First word of a frame: plus one enable round-trip.
- Back-to-back words with cmd_last = 0 keep SCS low; no disable is issued between them.
- cmd_last = 1 on the very first word of a frame produces an enable, DATA_BITS transfers, then a disable.

Optional Feature:
- Macro: SPI_BYTE_SEQUENCER_ABORT_EN.
- When defined:
  - Adds input port abort (1 bit).
  - abort = 1 in a REQ state: no new command is issued; go straight to S_DIS_REQ if frame_active, else S_IDLE.
  - abort = 1 in a WAIT state: the outstanding command finishes (wait for drv_ack), then the same rule applies.
  - rsp_valid is never pulsed for an aborted word.
  - In S_IDLE with abort = 1: cmd_ready = 0. If frame_active, the sequencer closes the frame (S_DIS_REQ).
  - abort and cmd_valid in the same cycle: abort wins and the word is not accepted.
- When undefined: no abort port; behaviour exactly as above.

Decomposition:
- Package spi_seq_pkg holds:
  - State encoding localparams: S_IDLE, S_EN_REQ, S_EN_WAIT, S_BIT_REQ, S_BIT_WAIT, S_DONE, S_DIS_REQ, S_DIS_WAIT (3-bit).
  - A default DATA_BITS constant.
- One sub-module is natural: spi_seq_cmd_issuer, a generic REQ/WAIT pulse-and-wait helper for a single driver command. It is optional; an inline FSM is acceptable.

Test Plan:
- Bench pairs the sequencer with a behavioural driver model that has a random 1-6 cycle ack delay and loops MOSI back to MISO.
- Single word 0xA5 with cmd_last = 1 -> exactly 1 enable, 8 transfers with drv_wdata = 1,0,1,0,0,1,0,1, then 1 disable; rsp_data = 0xA5; frame_active returns to 0.
- Words 0x3C (last = 0) then 0xFF (last = 1) back-to-back -> one enable, 16 transfers, one disable; rsp = 0x3C then 0xFF; frame_active stays high between the two words.
- Driver model with MISO tied to 0, word 0xFF -> rsp_data = 0x00; cmd_ready low throughout until the return to S_IDLE.
- drv_idle held low for 10 cycles in S_BIT_REQ -> no drv_do_* pulse until drv_idle rises; then exactly one pulse.
- reset_n low during the 4th bit -> next cycle all outputs are at their reset values; a new word 0x81 afterwards completes correctly.
- With SPI_BYTE_SEQUENCER_ABORT_EN: abort during the 3rd bit wait -> that transfer is acked, then a disable is issued; no rsp_valid; frame_active = 0.
